// File: rtl/timer_sampler.sv
// Avalon-MM master for the interval timer: turns start/sample commands into a
// clear/clock-select write or a counter read, with stall tolerance and a timeout.
module timer_sampler #(
    parameter int WIDTH     = 64,
    parameter int S_WIDTH_A = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_start,
    input  logic                   cmd_clk2x,
    input  logic                   cmd_sample,
    output logic                   cmd_ready,
    output logic [WIDTH-1:0]       result,
    output logic                   result_valid,
    output logic                   result_timeout,
    output logic [15:0]            sample_count,
    output logic [S_WIDTH_A-1:0]   m_address,
    output logic [WIDTH-1:0]       m_writedata,
    output logic [WIDTH/8-1:0]     m_byteenable,
    output logic                   m_read,
    output logic                   m_write,
    input  logic                   m_waitrequest,
    input  logic [WIDTH-1:0]       m_readdata,
    input  logic                   m_readdatavalid
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        WAIT_DATA
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          capture;
    logic          expire;
    logic [CW-1:0] tcnt;
    logic          clk2x_latched;

    assign m_address    = '0;
    assign m_byteenable = '1;
    assign m_writedata  = {{(WIDTH-1){1'b0}}, clk2x_latched};

    // Completion is tested before expiry so a last-cycle completion wins.
    // A read accepted on the final cycle without data cannot finish in time.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_start)
                    state_next = WRITE;
                else if (cmd_sample)
                    state_next = READ;
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    state_next = IDLE;
                end else if (tcnt == TLAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            READ: begin
                if (!m_waitrequest && m_readdatavalid) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else if (tcnt == TLAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end else if (!m_waitrequest) begin
                    state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (m_readdatavalid) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else if (tcnt == TLAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tcnt           <= '0;
            cmd_ready      <= 1'b1;
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            result         <= '0;
            result_valid   <= 1'b0;
            result_timeout <= 1'b0;
            sample_count   <= '0;
            clk2x_latched  <= 1'b0;
        end else begin
            state          <= state_next;
            tcnt           <= (state == IDLE) ? '0 : tcnt + 1'b1;
            cmd_ready      <= (state_next == IDLE);
            m_write        <= (state_next == WRITE);
            m_read         <= (state_next == READ);
            result_valid   <= capture;
            result_timeout <= expire;
            if (capture)
                result <= m_readdata;
            if (state == IDLE && cmd_start) begin
                clk2x_latched <= cmd_clk2x;
                sample_count  <= '0;
            end else if (capture && sample_count != 16'hFFFF) begin
                sample_count <= sample_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_timer_sampler.sv
// Randomized bench for timer_sampler: a duration-based transaction model predicts
// per-cycle handshake flags, completion/timeout pulses, result and sample_count.
module tb_timer_sampler;

    localparam int WIDTH = 64;
    localparam int SW    = 2;
    localparam int TO    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_start = 1'b0;
    logic              cmd_clk2x = 1'b0;
    logic              cmd_sample = 1'b0;
    logic              cmd_ready;
    logic [WIDTH-1:0]  result;
    logic              result_valid;
    logic              result_timeout;
    logic [15:0]       sample_count;
    logic [SW-1:0]     m_address;
    logic [WIDTH-1:0]  m_writedata;
    logic [WIDTH/8-1:0] m_byteenable;
    logic              m_read;
    logic              m_write;
    logic              m_waitrequest = 1'b0;
    logic [WIDTH-1:0]  m_readdata = '0;
    logic              m_readdatavalid = 1'b0;

    timer_sampler #(.WIDTH(WIDTH), .S_WIDTH_A(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_clk2x(cmd_clk2x), .cmd_sample(cmd_sample),
        .cmd_ready(cmd_ready), .result(result), .result_valid(result_valid),
        .result_timeout(result_timeout), .sample_count(sample_count),
        .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] exp_result = '0;
    logic [15:0]      exp_count  = '0;
    logic             exp_clk2x  = 1'b0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One transaction: w stall cycles before acceptance, l cycles of read latency
    // after acceptance. Busy time is w+1(+l) cycles unless that exceeds TO.
    task automatic run_txn(input bit is_start, input bit is_sample, input bit clk2x,
                           input int w, input int l, input bit noise, input string tag);
        int t, e, req_len;
        bit done, is_wr, req;
        logic [WIDTH-1:0] data;
        logic [4:0] exp_f, got_f;
        logic [WIDTH-1:0] exp_wd;
        is_wr   = is_start;
        t       = is_wr ? w + 1 : w + 1 + l;
        done    = (t <= TO);
        e       = done ? t : TO;
        req_len = (w + 1 < e) ? w + 1 : e;
        data    = {$urandom, $urandom};
        cmd_start       = is_start;
        cmd_sample      = is_sample;
        cmd_clk2x       = clk2x;
        m_readdatavalid = 1'b0;
        for (int k = 1; k <= e + 1; k++) begin
            step;
            req   = (k <= req_len);
            exp_f = {req && is_wr, req && !is_wr, k == e + 1,
                     (k == e + 1) && done && !is_wr, (k == e + 1) && !done};
            got_f = {m_write, m_read, cmd_ready, result_valid, result_timeout};
            n_cmp++;
            if (got_f !== exp_f) begin
                n_bad++;
                $display("FAIL %s flags{wr,rd,rdy,val,tmo} cycle %0d: got %b want %b",
                         tag, k, got_f, exp_f);
            end
            if (k == e + 1) begin
                if (is_wr) begin
                    exp_count = '0;
                    exp_clk2x = clk2x;
                end else if (done) begin
                    exp_result = data;
                    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
                end
                exp_wd = {{(WIDTH-1){1'b0}}, exp_clk2x};
                n_cmp++;
                if (result !== exp_result) begin
                    n_bad++;
                    $display("FAIL %s result: got %h want %h", tag, result, exp_result);
                end
                n_cmp++;
                if (sample_count !== exp_count) begin
                    n_bad++;
                    $display("FAIL %s sample_count: got %0d want %0d", tag, sample_count, exp_count);
                end
                n_cmp++;
                if (m_writedata !== exp_wd) begin
                    n_bad++;
                    $display("FAIL %s m_writedata: got %h want %h", tag, m_writedata, exp_wd);
                end
            end
            if (noise && k <= e) begin
                cmd_start  = 1'($urandom_range(0, 1));
                cmd_sample = 1'($urandom_range(0, 1));
                cmd_clk2x  = 1'($urandom_range(0, 1));
            end else begin
                cmd_start  = 1'b0;
                cmd_sample = 1'b0;
            end
            m_waitrequest = (k <= w) ? 1'b1 : (k == w + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!is_wr)
                m_readdatavalid = (k == w + 1 + l);
            else
                m_readdatavalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            m_readdata = (!is_wr && m_readdatavalid) ? data : {$urandom, $urandom};
        end
        cmd_start       = 1'b0;
        cmd_sample      = 1'b0;
        m_readdatavalid = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        logic [4:0] got_f;
        for (int i = 0; i < n; i++) begin
            m_waitrequest   = 1'($urandom_range(0, 1));
            m_readdatavalid = 1'($urandom_range(0, 1));
            m_readdata      = {$urandom, $urandom};
            step;
            got_f = {m_write, m_read, cmd_ready, result_valid, result_timeout};
            n_cmp++;
            if (got_f !== 5'b00100 || result !== exp_result) begin
                n_bad++;
                $display("FAIL %s idle cycle %0d: flags %b result %h want flags 00100 result %h",
                         tag, i, got_f, result, exp_result);
            end
        end
        m_readdatavalid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        n_cmp++;
        if ({m_write, m_read, cmd_ready, result_valid, result_timeout} !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset flags: got %b want 00100",
                     {m_write, m_read, cmd_ready, result_valid, result_timeout});
        end
        n_cmp++;
        if (result !== '0 || sample_count !== 16'd0 || m_writedata !== '0) begin
            n_bad++;
            $display("FAIL reset values: result %h count %0d wdata %h want 0 0 0",
                     result, sample_count, m_writedata);
        end
        n_cmp++;
        if (m_address !== '0 || m_byteenable !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset constants: addr %0d be %h want 0 ff", m_address, m_byteenable);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_zero_latency;
        run_txn(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, "zl_start");
        idle_cycles(10, "zl_idle");
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "zl_sample");
    endtask

    task automatic test_stall_latency;
        run_txn(1'b0, 1'b1, 1'b0, 3, 4, 1'b0, "stall3_lat4");
        run_txn(1'b1, 1'b0, 1'b0, 2, 0, 1'b0, "write_stall2");
    endtask

    task automatic test_start_and_sample;
        run_txn(1'b0, 1'b1, 1'b0, 0, 1, 1'b0, "pre_sample");
        run_txn(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, "start_and_sample");
        idle_cycles(3, "after_both");
    endtask

    task automatic test_commands_ignored;
        run_txn(1'b0, 1'b1, 1'b0, 1, 6, 1'b1, "busy_cmds_read");
        run_txn(1'b1, 1'b0, 1'b0, 4, 0, 1'b1, "busy_cmds_write");
        idle_cycles(2, "after_busy");
    endtask

    task automatic test_timeout;
        run_txn(1'b0, 1'b1, 1'b0, 40, 0, 1'b0, "stuck_read");
        run_txn(1'b1, 1'b0, 1'b1, 40, 0, 1'b0, "stuck_write");
        run_txn(1'b0, 1'b1, 1'b0, 0, 30, 1'b0, "lost_data");
        run_txn(1'b0, 1'b1, 1'b0, 15, 0, 1'b0, "read_at_limit");
        run_txn(1'b0, 1'b1, 1'b0, 14, 1, 1'b0, "wait_at_limit");
        run_txn(1'b0, 1'b1, 1'b0, 15, 1, 1'b0, "read_past_limit");
        run_txn(1'b1, 1'b0, 1'b0, 15, 0, 1'b0, "write_at_limit");
        run_txn(1'b1, 1'b0, 1'b0, 16, 0, 1'b0, "write_past_limit");
    endtask

    task automatic test_back_to_back;
        int kind, w, l;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 4);
            run_txn(kind == 0 || kind == 5, kind != 0, 1'($urandom_range(0, 1)),
                    w, l, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_mid_read;
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "pre_reset_read");
        cmd_sample = 1'b1;
        step;
        cmd_sample    = 1'b0;
        m_waitrequest = 1'b0;
        step;
        m_waitrequest = 1'b1;
        step;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({m_write, m_read, cmd_ready, result_valid, result_timeout} !== 5'b00100 ||
            result !== '0 || sample_count !== 16'd0 || m_writedata !== '0) begin
            n_bad++;
            $display("FAIL async_reset: flags %b result %h count %0d wdata %h want 00100 0 0 0",
                     {m_write, m_read, cmd_ready, result_valid, result_timeout},
                     result, sample_count, m_writedata);
        end
        exp_result = '0;
        exp_count  = '0;
        exp_clk2x  = 1'b0;
        step;
        reset = 1'b0;
        m_readdatavalid = 1'b1;
        m_readdata      = {$urandom, $urandom};
        step;
        m_readdatavalid = 1'b0;
        step;
        n_cmp++;
        if ({m_write, m_read, cmd_ready, result_valid, result_timeout} !== 5'b00100 ||
            result !== '0 || sample_count !== 16'd0) begin
            n_bad++;
            $display("FAIL late_data_after_reset: flags %b result %h count %0d want 00100 0 0",
                     {m_write, m_read, cmd_ready, result_valid, result_timeout},
                     result, sample_count);
        end
        run_txn(1'b0, 1'b1, 1'b0, 1, 2, 1'b0, "post_reset_read");
    endtask

    initial begin
        reset = 1'b1;
        test_reset;
        test_zero_latency;
        test_stall_latency;
        test_start_and_sample;
        test_commands_ignored;
        test_timeout;
        test_back_to_back;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_sampler.md
# timer_sampler

Avalon-MM master that drives the free-running interval timer slave on the host-control side of the accelerator system. A controller issues one-cycle start and sample commands. The block converts them into a clear/clock-select write and a counter read, and returns the sampled count with a valid pulse. It tolerates arbitrary waitrequest stalls and read latency, including zero-latency readdatavalid, and recovers from a hung slave with a timeout.

## Interface
- WIDTH, 64: timer data width; also the result width.
- S_WIDTH_A, 2: slave word-address width.
- TIMEOUT, 1024: cycles allowed per transaction before abort; must be ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  pulse: clear the timer and select its clock source.
- cmd_clk2x  in  1  sampled with cmd_start; 1 selects the 2x counter.
- cmd_sample  in  1  pulse: read the current timer count.
- cmd_ready  out  1  high in IDLE; commands are accepted only while high.
- result  out  WIDTH  last successfully read count; held until the next successful read.
- result_valid  out  1  one-cycle pulse when result updates.
- result_timeout  out  1  one-cycle pulse when a transaction is aborted.
- sample_count  out  16  successful reads since the last start; saturates at 0xFFFF.
- m_address  out  S_WIDTH_A  constant 0.
- m_writedata  out  WIDTH  {(WIDTH-1)'b0, clk2x_latched}.
- m_byteenable  out  WIDTH/8  all ones.
- m_read  out  1  read request.
- m_write  out  1  write request.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  WIDTH  read data.
- m_readdatavalid  in  1  read data qualifier.

## Operation
- FSM states: IDLE, WRITE, READ, WAIT_DATA.
- IDLE:
  - cmd_start=1 latches cmd_clk2x, clears sample_count and moves to WRITE.
  - Otherwise cmd_sample=1 moves to READ.
  - If both are high in the same cycle, start wins and the sample is dropped.
  - Commands outside IDLE are ignored with no side effect.
- WRITE: m_write=1 and the write data are held stable. On a cycle with m_waitrequest=0 the write is accepted; go to IDLE.
- READ: m_read=1 is held stable. On a cycle with m_waitrequest=0 the read is accepted:
  - if m_readdatavalid=1 in the same cycle, capture m_readdata and go to IDLE;
  - else go to WAIT_DATA.
- WAIT_DATA: on m_readdatavalid=1, capture the data and go to IDLE.
- Capture effects: result ← m_readdata; result_valid pulses; sample_count increments (saturating).
- m_readdatavalid outside READ/WAIT_DATA is ignored. At most one read is outstanding.
- Timeout:
  - A cycle counter clears on entry to WRITE/READ and runs through WRITE, READ and WAIT_DATA.
  - When it reaches TIMEOUT-1 without completion: drop the request, pulse result_timeout, leave result and sample_count unchanged, go to IDLE.
  - If completion and expiry fall in the same cycle, completion wins.
- No arithmetic is done on result; it is the raw counter value.

## Timing
- All outputs are registered.
- Reset values: state IDLE, cmd_ready=1, m_read=0, m_write=0, result=0, result_valid=0, result_timeout=0, sample_count=0, clk2x_latched=0. m_writedata therefore resets to 0.
- Reset asserted mid-transaction drops the request immediately (asynchronously). No completion pulse follows.
- Command at edge N → request asserted and cmd_ready=0 from cycle N+1.
- Best-case write: accepted at edge N+1; cmd_ready=1 in cycle N+2.
- Best-case read with zero-latency readdatavalid: capture at edge N+1; result_valid and new result in cycle N+2; cmd_ready=1 in cycle N+2.
- Each waitrequest cycle or readdatavalid latency cycle adds one cycle.
- Requests never deassert while m_waitrequest=1, except on timeout or reset.

## Test plan
- Zero-latency slave, no stall: cmd_start with cmd_clk2x=1 → one-cycle m_write with m_writedata=1; after 10 idle cycles cmd_sample → m_read for 1 cycle, result_valid two cycles after the command, result equals the slave counter value, sample_count=1.
- waitrequest held 3 cycles on a read with readdatavalid 4 cycles after accept → m_read high for exactly 4 cycles, single result_valid, result=m_readdata at the valid cycle.
- cmd_start and cmd_sample in the same cycle → only a write issued; m_read never asserted; sample_count=0.
- Commands pulsed while a read is outstanding → ignored; exactly one transaction completes.
- Slave stuck with waitrequest=1, TIMEOUT=16 → m_read deasserts after 16 cycles, result_timeout pulses once, result unchanged, cmd_ready=1.
- Reset asserted while in WAIT_DATA, then a late readdatavalid arrives → all outputs at reset values, no result_valid, FSM idle.
